// File: rtl/matrix_4x4_unbuff.sv
`default_nettype none
// ============================================================================
// Module   : matrix_4x4_unbuff
// Purpose  : Result-side serializer for the 4x4 fixed-point matrix path.
//            Captures a whole 4x4 matrix (four parallel columns) in one
//            valid/ready transfer, then streams the 16 elements one per beat.
//            The order is column C1 rows 0..3, then C2, C3, C4.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            valid_in        - parallel matrix on cC1..cC4 is valid
//            ready_out       - block can capture a matrix this cycle
//            cC1..cC4        - matrix columns, index = row
//            valid_out       - c_out holds a valid element
//            ready_in        - downstream accepts c_out this cycle
//            c_out           - current element (bit-exact pass-through)
//            elem_idx        - col*4 + row of current element
//            last_out        - high with the 16th element
// Revision : 1.0 - initial release
// ============================================================================
module matrix_4x4_unbuff #(
  parameter int W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic [3:0][W-1:0]   cC1,
  input  logic [3:0][W-1:0]   cC2,
  input  logic [3:0][W-1:0]   cC3,
  input  logic [3:0][W-1:0]   cC4,
  output logic                valid_out,
  input  logic                ready_in,
  output logic [W-1:0]        c_out,
  output logic [3:0]          elem_idx,
  output logic                last_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     ready_nxt;
  logic                     valid_nxt;
  logic [3:0]               idx_nxt;
  logic                     capture;

  // Snapshot buffer, indexed [column][row].
  logic [3:0][3:0][W-1:0]   mat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_out <= 1'b0;
      valid_out <= 1'b0;
      elem_idx  <= 4'd0;
      mat       <= '0;
    end else begin
      state     <= state_nxt;
      ready_out <= ready_nxt;
      valid_out <= valid_nxt;
      elem_idx  <= idx_nxt;
      if (capture) begin
        mat[0] <= cC1;
        mat[1] <= cC2;
        mat[2] <= cC3;
        mat[3] <= cC4;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready_nxt = ready_out;
    valid_nxt = valid_out;
    idx_nxt   = elem_idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // ready_out is registered, so it only rises one edge after entering
        // IDLE; a capture is therefore impossible right after reset release.
        ready_nxt = 1'b1;
        valid_nxt = 1'b0;
        if (valid_in && ready_out) begin
          capture   = 1'b1;
          ready_nxt = 1'b0;
          valid_nxt = 1'b1;
          idx_nxt   = 4'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        ready_nxt = 1'b0;
        if (valid_out && ready_in) begin
          if (elem_idx == 4'd15) begin
            valid_nxt = 1'b0;
            ready_nxt = 1'b1;
            idx_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = elem_idx + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b0;
        valid_nxt = 1'b0;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  assign c_out    = mat[elem_idx[3:2]][elem_idx[1:0]];
  assign last_out = valid_out && (elem_idx == 4'd15);

endmodule
`default_nettype wire

// File: tb/tb_matrix_4x4_unbuff.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_4x4_unbuff
// Purpose  : Self-checking bench for matrix_4x4_unbuff. Stimulus pushes the
//            expected element stream into a queue on capture; a monitor pops
//            and compares on every accepted beat and checks hold stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_4x4_unbuff;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic              ready_out;
  logic [3:0][W-1:0] cC1, cC2, cC3, cC4;
  logic              valid_out;
  logic              ready_in;
  logic [W-1:0]      c_out;
  logic [3:0]        elem_idx;
  logic              last_out;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  matrix_4x4_unbuff #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .cC1       (cC1),
    .cC2       (cC2),
    .cC3       (cC3),
    .cC4       (cC4),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .c_out     (c_out),
    .elem_idx  (elem_idx),
    .last_out  (last_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         have_prev = 1'b0;
  logic [W-1:0] prev_c;
  logic [3:0]   prev_idx;
  logic         prev_last;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        chk("hold_data", {20'd0, c_out}, {20'd0, prev_c});
        chk("hold_idx", {28'd0, elem_idx}, {28'd0, prev_idx});
        chk("hold_last", {31'd0, last_out}, {31'd0, prev_last});
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h idx %0d, none expected", c_out, elem_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {20'd0, c_out}, {20'd0, e.data});
          chk("beat_idx", {28'd0, elem_idx}, {28'd0, e.idx});
          chk("beat_last", {31'd0, last_out}, {31'd0, e.last});
        end
        have_prev = 1'b0;
      end else if (valid_out) begin
        have_prev = 1'b1;
        prev_c    = c_out;
        prev_idx  = elem_idx;
        prev_last = last_out;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] m[16];

  task automatic load_seq(input int base);
    for (int k = 0; k < 16; k++) m[k] = W'(base + k + 1);
  endtask

  task automatic drive_m();
    for (int r = 0; r < 4; r++) begin
      cC1[r] = m[r];
      cC2[r] = m[4 + r];
      cC3[r] = m[8 + r];
      cC4[r] = m[12 + r];
    end
  endtask

  task automatic push_m();
    beat_t b;
    for (int k = 0; k < 16; k++) begin
      b.data = m[k];
      b.idx  = 4'(k);
      b.last = (k == 15);
      exp_q.push_back(b);
    end
  endtask

  // Present m with valid_in, wait for ready_out, capture. Returns #1 after
  // the capture edge.
  task automatic capture(input logic hold_vin);
    int n = 0;
    drive_m();
    valid_in = 1'b1;
    ready_in = 1'b0;
    while (!ready_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: ready_out %0b required 1", ready_out);
    end
    push_m();
    @(posedge clk); #1;
    chk("first_valid", {31'd0, valid_out}, 32'd1);
    chk("first_idx", {28'd0, elem_idx}, 32'd0);
    if (!hold_vin) valid_in = 1'b0;
  endtask

  task automatic stream(input logic bp, input logic drop_vin, input int exp_edges);
    int   edges = 0;
    logic rdy_seen = 1'b0;
    while (valid_out && edges < 100) begin
      if (ready_out) rdy_seen = 1'b1;
      ready_in = bp ? edges[0] : 1'b1;
      if (drop_vin && last_out && ready_in) valid_in = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    chk("ready_low_in_send", {31'd0, rdy_seen}, 32'd0);
    chk("stream_edges", edges, exp_edges);
    chk("ready_after_last", {31'd0, ready_out}, 32'd1);
    chk("valid_after_last", {31'd0, valid_out}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    cC1 = '0; cC2 = '0; cC3 = '0; cC4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_idx", {28'd0, elem_idx}, 32'd0);
    chk("rst_cout", {20'd0, c_out}, 32'd0);
    chk("rst_last", {31'd0, last_out}, 32'd0);
    rst = 1'b0;
    valid_in = 1'b1;                  // must not capture in first cycle
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, ready_out}, 32'd1);
    chk("post_rst_no_cap", {31'd0, valid_out}, 32'd0);
    valid_in = 1'b0;

    // Basic stream: 1..16 with ready_in high
    load_seq(0);
    capture(1'b0);
    stream(1'b0, 1'b0, 16);

    // Backpressure: ready_in 0,1,0,1...; last beat 32 edges after capture
    capture(1'b0);
    stream(1'b1, 1'b0, 32);

    // Input isolation: inputs scrambled and valid_in held during SEND
    capture(1'b1);
    for (int r = 0; r < 4; r++) begin
      cC1[r] = 12'hAAA; cC2[r] = 12'hAAA; cC3[r] = 12'hAAA; cC4[r] = 12'hAAA;
    end
    stream(1'b0, 1'b1, 16);
    @(posedge clk); #1;
    chk("iso_no_recapture", {31'd0, valid_out}, 32'd0);

    // Back-to-back: A = 1..16, then B = 17..32 with valid_in held
    load_seq(0);
    capture(1'b1);
    load_seq(16);
    drive_m();
    stream(1'b0, 1'b0, 16);
    push_m();                          // B captured on this edge
    @(posedge clk); #1;
    chk("b2b_gap_one", {31'd0, valid_out}, 32'd1);
    chk("b2b_ready", {31'd0, ready_out}, 32'd0);
    valid_in = 1'b0;
    stream(1'b0, 1'b0, 16);

    // Reset mid-stream after 5 accepted beats
    load_seq(0);
    capture(1'b0);
    ready_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_idx5", {28'd0, elem_idx}, 32'd5);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_out}, 32'd0);
    chk("mid_rst_cout", {20'd0, c_out}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_ready2", {31'd0, ready_out}, 32'd1);
    load_seq(100);
    capture(1'b0);
    stream(1'b0, 1'b0, 16);

    // Signed / extreme values at known positions
    load_seq(0);
    m[0]  = 12'hFFF;                   // C1 row 0
    m[6]  = 12'h800;                   // C2 row 2
    m[15] = 12'h7FF;                   // C4 row 3
    m[9]  = 12'h801;                   // C3 row 1
    capture(1'b0);
    stream(1'b1, 1'b0, 32);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/matrix_4x4_unbuff.md
Name: matrix_4x4_unbuff

Overview:
- Result-side serializer for the 4x4 fixed-point matrix path.
- Accepts one complete 4x4 matrix of W-bit elements, presented as four parallel columns, in a single valid/ready transfer.
- Snapshots the matrix into an internal buffer, then streams the 16 elements one per beat over a valid/ready interface. Order: column C1 rows 0..3, then C2, C3, C4.
- Sits between the matrix multiplier output and the narrow element-wide result stream.

Parameters:
- W, 12, element width in bits (fixed-point 12:10); data is passed through unmodified.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- valid_in  in  1  parallel matrix on cC1..cC4 is valid
- ready_out  out  1  block can capture a matrix this cycle
- cC1  in  [3:0][W-1:0]  column 1, index = row
- cC2  in  [3:0][W-1:0]  column 2
- cC3  in  [3:0][W-1:0]  column 3
- cC4  in  [3:0][W-1:0]  column 4
- valid_out  out  1  c_out holds a valid element
- ready_in  in  1  downstream accepts c_out this cycle
- c_out  out  W  current element
- elem_idx  out  4  index of current element = col*4 + row (col 0..3 maps to C1..C4)
- last_out  out  1  high with the 16th element (elem_idx == 15)

Behaviour:
- Reset is synchronous. When rst is high at a clock edge:
  - state <= IDLE; ready_out <= 0; valid_out <= 0; elem_idx <= 0.
  - All 16 buffer entries <= 0, so c_out reads 0.
  - rst overrides every other event in that cycle.
- States: IDLE, SEND.
- IDLE:
  - ready_out <= 1 each cycle; valid_out = 0.
  - Capture occurs on an edge where valid_in && ready_out. On that edge: buffer <= cC1..cC4, elem_idx <= 0, ready_out <= 0, valid_out <= 1, state <= SEND.
  - First cycle after reset release: ready_out = 0. It rises at the following edge, so a capture can never happen in that first cycle.
- SEND:
  - ready_out = 0. valid_in and cC1..cC4 are ignored; input changes after capture do not affect output.
  - c_out = buffer[elem_idx[3:2]][elem_idx[1:0]]. This is a combinational read of registered data.
  - A beat transfers on an edge with valid_out && ready_in:
    - If elem_idx < 15: elem_idx <= elem_idx + 1.
    - If elem_idx == 15: valid_out <= 0, ready_out <= 1, elem_idx <= 0, state <= IDLE.
  - With valid_out high and ready_in low: c_out, elem_idx and last_out hold stable indefinitely. valid_out never drops before the beat is accepted.
- last_out = valid_out && (elem_idx == 15). It is combinational from registers.
- Latency:
  - First element is valid the cycle after capture.
  - With ready_in held high, 16 consecutive beats follow.
  - ready_out is high the cycle after the last beat.
  - Minimum period is 17 cycles per matrix: one capture cycle plus 16 beats. There is no overlap of capture and streaming.
- Arithmetic: none. Elements are passed bit-exact, including sign bit. elem_idx wraps only through the 15 -> 0 path in SEND.
- Reset mid-stream: the remaining elements are discarded, with no partial-matrix signalling. The next matrix streams from elem_idx 0.
- ready_in is a don't-care while valid_out is low.

Test Plan:
- Basic stream:
  - Stimulus: reset 2 cycles; cCj[i] = 4*(j-1)+i+1; valid_in pulse when ready_out=1; ready_in held 1.
  - Response: c_out = 1,2,...,16 on 16 consecutive cycles starting the cycle after capture; elem_idx 0..15; last_out only with value 16; ready_out = 1 the cycle after.
- Backpressure:
  - Stimulus: same matrix; ready_in alternates 0,1 starting at 0.
  - Response: each value is held while ready_in = 0; sequence is still 1..16; the 16th element is accepted 32 cycles after capture; no element is duplicated or skipped.
- Input isolation:
  - Stimulus: after capture, drive all cC* to 12'hAAA and hold valid_in = 1.
  - Response: output stream is still 1..16; ready_out stays 0 throughout SEND; no second capture until IDLE.
- Back-to-back:
  - Stimulus: valid_in held 1; matrix A = 1..16, then matrix B = 17..32 presented once ready_out returns; ready_in = 1.
  - Response: B is captured on the first cycle ready_out = 1; exactly one cycle with valid_out = 0 between A's element 16 and B's element 17.
- Reset mid-stream:
  - Stimulus: rst for 1 cycle after 5 accepted beats.
  - Response: next cycle valid_out = 0, ready_out = 0, c_out = 0; the cycle after that ready_out = 1; a new matrix streams from elem_idx 0.
- Signed values:
  - Stimulus: matrix containing 12'hFFF, 12'h800 and 12'h7FF.
  - Response: values appear bit-exact on c_out at elem_idx matching their col*4+row positions.
